// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x6 matrix keypad column scanner with debounce and key-event pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [5:0] col_n,
    output logic       newhex,
    output logic [3:0] hexcode,
    output logic       newop,
    output logic [1:0] opcode,
    output logic       eq,
    output logic       key_down
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  C_DEB_M1    = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PRESS   = 2'd1,
        S_HELD    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    logic [3:0]        r_row_s1;
    logic [3:0]        r_row_s2;
    logic [SLOT_W-1:0] r_slot;
    logic [2:0]        r_col;
    logic [5:0]        r_col_n;
    logic [1:0]        r_acc_n;
    logic [4:0]        r_acc_k;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nx;
    logic [4:0]        r_cand;
    logic [4:0]        w_cand_nx;
    logic              w_accept;
    logic              w_release;

    logic              r_newhex;
    logic              r_newop;
    logic              r_eq;
    logic [3:0]        r_hexcode;
    logic [1:0]        r_opcode;
    logic              r_key_down;

    logic              w_sample;
    logic              w_scan_end;
    logic [3:0]        w_lows;
    logic [2:0]        w_col_cnt;
    logic [2:0]        w_tot_raw;
    logic [1:0]        w_tot;
    logic [1:0]        w_row;
    logic [4:0]        w_res_k;
    logic              w_res_key;
    logic              w_res_none;

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
        end else begin
            r_row_s1 <= row_n;
            r_row_s2 <= r_row_s1;
        end
    end

    assign w_sample   = (r_slot == C_SLOT_LAST);
    assign w_scan_end = w_sample && (r_col == 3'd5);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot  <= '0;
            r_col   <= 3'd0;
            r_col_n <= 6'b111110;
        end else if (w_sample) begin
            r_slot <= '0;
            if (r_col == 3'd5) begin
                r_col   <= 3'd0;
                r_col_n <= 6'b111110;
            end else begin
                r_col   <= r_col + 3'd1;
                r_col_n <= {r_col_n[4:0], 1'b1};
            end
        end else begin
            r_slot <= r_slot + 1'b1;
        end
    end

    // Per-column row evaluation; the low count saturates at 2 (meaning MULTI)
    assign w_lows    = ~r_row_s2;
    assign w_col_cnt = {2'b00, w_lows[0]} + {2'b00, w_lows[1]}
                     + {2'b00, w_lows[2]} + {2'b00, w_lows[3]};
    assign w_tot_raw = {1'b0, r_acc_n} + w_col_cnt;
    assign w_tot     = (w_tot_raw >= 3'd2) ? 2'd2 : w_tot_raw[1:0];

    always_comb begin
        w_row = 2'd0;
        for (int r = 3; r >= 0; r--) begin
            if (w_lows[r]) begin
                w_row = 2'(r);
            end
        end
    end

    assign w_res_k    = (w_col_cnt == 3'd1) ? {r_col, w_row} : r_acc_k;
    assign w_res_key  = (w_tot == 2'd1) && (w_res_k <= 5'd20);
    assign w_res_none = (w_tot == 2'd0) || ((w_tot == 2'd1) && (w_res_k > 5'd20));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc_n <= 2'd0;
            r_acc_k <= 5'd0;
        end else if (w_scan_end) begin
            r_acc_n <= 2'd0;
            r_acc_k <= 5'd0;
        end else if (w_sample) begin
            r_acc_n <= w_tot;
            r_acc_k <= w_res_k;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= 5'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_cand  <= w_cand_nx;
        end
    end

    // Debounce FSM, advanced only on the scan-end sample
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cand_nx  = r_cand;
        w_accept   = 1'b0;
        w_release  = 1'b0;
        if (w_scan_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_res_key) begin
                        w_cand_nx = w_res_k;
                        if (DEBOUNCE == 1) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx   = C_CNT_ONE;
                            w_state_nx = S_PRESS;
                        end
                    end
                end
                S_PRESS: begin
                    if (w_res_key && (w_res_k == r_cand)) begin
                        if (r_cnt == C_DEB_M1) begin
                            w_accept   = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_HELD;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (w_res_none) begin
                        if (DEBOUNCE == 1) begin
                            w_release  = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_cnt_nx   = C_CNT_ONE;
                            w_state_nx = S_RELEASE;
                        end
                    end
                end
                default: begin
                    if (w_res_none) begin
                        if (r_cnt == C_DEB_M1) begin
                            w_release  = 1'b1;
                            w_cnt_nx   = '0;
                            w_state_nx = S_IDLE;
                        end else begin
                            w_cnt_nx = r_cnt + 1'b1;
                        end
                    end else begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_HELD;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_newhex   <= 1'b0;
            r_newop    <= 1'b0;
            r_eq       <= 1'b0;
            r_hexcode  <= 4'd0;
            r_opcode   <= 2'd0;
            r_key_down <= 1'b0;
        end else begin
            r_newhex <= 1'b0;
            r_newop  <= 1'b0;
            r_eq     <= 1'b0;
            if (w_accept) begin
                r_key_down <= 1'b1;
                if (w_cand_nx < 5'd16) begin
                    r_newhex  <= 1'b1;
                    r_hexcode <= w_cand_nx[3:0];
                end else if (w_cand_nx < 5'd20) begin
                    r_newop  <= 1'b1;
                    r_opcode <= w_cand_nx[1:0];
                end else begin
                    r_eq <= 1'b1;
                end
            end else if (w_release) begin
                r_key_down <= 1'b0;
            end
        end
    end

    assign col_n    = r_col_n;
    assign newhex   = r_newhex;
    assign newop    = r_newop;
    assign eq       = r_eq;
    assign hexcode  = r_hexcode;
    assign opcode   = r_opcode;
    assign key_down = r_key_down;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// Module   : tb_keypad_scanner
// Purpose  : Directed + random keypad stimulus against a scan-level debounce model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN     = 6 * SCAN_DIV;
    localparam int R_NONE   = -1;
    localparam int R_MULTI  = -2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [5:0]  col_n;
    logic        newhex;
    logic [3:0]  hexcode;
    logic        newop;
    logic [1:0]  opcode;
    logic        eq;
    logic        key_down;

    logic [23:0] pressed = '0;

    int checks   = 0;
    int failures = 0;

    // Scan-level model state
    int m_kd, m_streak, m_cand, m_rel, m_hex, m_op;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB)) dut (
        .clock    (clock),
        .reset    (reset),
        .row_n    (row_n),
        .col_n    (col_n),
        .newhex   (newhex),
        .hexcode  (hexcode),
        .newop    (newop),
        .opcode   (opcode),
        .eq       (eq),
        .key_down (key_down)
    );

    always #5 clock = ~clock;

    // Physical keypad: a pressed key shorts its row to its column
    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 6; c++)
            for (int r = 0; r < 4; r++)
                if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int scan_result(input logic [23:0] mask);
        int n;
        n = $countones(mask);
        if (n == 0) return R_NONE;
        if (n > 1)  return R_MULTI;
        for (int k = 0; k < 24; k++)
            if (mask[k]) return (k > 20) ? R_NONE : k;
        return R_NONE;
    endfunction

    task automatic model_reset();
        m_kd = 0; m_streak = 0; m_cand = 0; m_rel = 0; m_hex = 0; m_op = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_col_n", int'(col_n), 6'b111110);
        chk("rst_pulses", int'({newhex, newop, eq}), 0);
        chk("rst_hexcode", int'(hexcode), 0);
        chk("rst_opcode", int'(opcode), 0);
        chk("rst_key_down", int'(key_down), 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // One full scan with the given keys held; checks every cycle
    task automatic do_scan(input logic [23:0] mask);
        int res, exp_p, col;
        pressed = mask;
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge clock);
            #1;
            col = (i / SCAN_DIV) % 6;
            chk("col_n", int'(col_n), 63 ^ (1 << col));
            if (i < SCAN) begin
                chk("no_pulse_midscan", int'({newhex, newop, eq}), 0);
            end else begin
                res   = scan_result(mask);
                exp_p = 0;
                if (m_kd == 0) begin
                    if (res >= 0 && m_streak > 0 && res == m_cand) m_streak++;
                    else if (res >= 0 && m_streak == 0) begin m_cand = res; m_streak = 1; end
                    else m_streak = 0;
                    if (m_streak == DEB) begin
                        m_kd = 1; m_streak = 0; m_rel = 0;
                        if (m_cand < 16) begin exp_p = 4; m_hex = m_cand; end
                        else if (m_cand < 20) begin exp_p = 2; m_op = m_cand - 16; end
                        else exp_p = 1;
                    end
                end else begin
                    if (res == R_NONE) m_rel++; else m_rel = 0;
                    if (m_rel == DEB) begin m_kd = 0; m_rel = 0; end
                end
                chk("pulses", int'({newhex, newop, eq}), exp_p);
                chk("hexcode", int'(hexcode), m_hex);
                chk("opcode", int'(opcode), m_op);
                chk("key_down", int'(key_down), m_kd);
            end
        end
    endtask

    task automatic scans(input logic [23:0] mask, input int n);
        for (int s = 0; s < n; s++) do_scan(mask);
    endtask

    task automatic partial(input logic [23:0] mask, input int cycles);
        pressed = mask;
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] key(input int k);
        logic [23:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    initial begin
        logic [23:0] rmask;
        int sel;
        #2;
        do_reset();
        // Idle scanning, no keys
        scans('0, 9);
        // Hex key 11 held then released
        scans(key(11), 10);
        scans('0, 4);
        // Operator 18, then equals 20
        scans(key(18), 4);
        scans('0, 4);
        scans(key(20), 4);
        scans('0, 4);
        // Bounce: alternating press/release, then held with a one-scan glitch
        for (int s = 0; s < 4; s++) begin
            do_scan(key(5));
            do_scan('0);
        end
        scans(key(5), 4);
        do_scan('0);
        scans(key(5), 3);
        scans('0, 4);
        // Multi and unused keys
        scans(key(1) | key(6), 6);
        scans('0, 3);
        scans(key(22), 5);
        scans('0, 3);
        scans(key(1), 4);
        scans(key(1) | key(6), 4);
        scans('0, 4);
        // Reset during PRESS, key still held afterwards
        scans(key(7), 2);
        partial(key(7), 10);
        do_reset();
        scans(key(7), 4);
        // Reset during HELD
        scans(key(7), 2);
        partial(key(7), 5);
        do_reset();
        scans(key(7), 4);
        scans('0, 4);
        // Random keypad activity
        rmask = '0;
        for (int s = 0; s < 60; s++) begin
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 5) rmask = '0;
            else if (sel >= 6 && sel <= 7) rmask = key($urandom_range(0, 23));
            else if (sel == 8) rmask = key($urandom_range(0, 23)) | key($urandom_range(0, 23));
            else if (sel == 9) rmask = key($urandom_range(16, 23));
            do_scan(rmask);
        end
        scans('0, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4-row x 6-column matrix keypad and debounces the result.
- Produces the single-cycle key events consumed by the calculator register block: newhex/hexcode, newop/opcode, eq.
- Sits between the board keypad pins and the register/arithmetic datapath; one event per physical press, no auto-repeat.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven before its rows are sampled (min 4).
- DEBOUNCE, 4, consecutive identical full-scan results required to accept a press or a release (min 1).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- row_n  input  4  keypad rows, active-low, externally pulled up, asynchronous to clock
- col_n  output  6  keypad column drive, active-low, exactly one bit low at any time
- newhex  output  1  one-cycle pulse: hex key accepted
- hexcode  output  4  value of last accepted hex key; held between pulses
- newop  output  1  one-cycle pulse: operator key accepted
- opcode  output  2  code of last accepted operator key; held between pulses
- eq  output  1  one-cycle pulse: equals key accepted
- key_down  output  1  level: a press is accepted and not yet released

Behaviour:
- Reset (reset=0, async): col_n=6'b111110; all pulses, hexcode, opcode and key_down = 0; counters 0; FSM=IDLE; synchroniser flops = 4'hF.
- Synchronisation: row_n passes through 2 flops before use.
- Scan:
  - Slot counter 0..SCAN_DIV-1; column index c = 0..5 wraps to 0.
  - col_n has bit c low; it advances on the slot-counter wrap.
  - On the last cycle of slot c, synchronised rows are captured for column c.
  - Full scan = 6*SCAN_DIV cycles and ends at the column-5 sample.
- Scan result at end of each full scan:
  - NONE: no row low in any column.
  - KEY(k): exactly one row/column low; k = c*4 + r.
  - MULTI: two or more low.
- Key map:
  - k 0..15: hex value k.
  - k 16..19: operator, opcode = k-16.
  - k 20: equals.
  - k 21..23: unused, treated as NONE.
- FSM, evaluated once per full scan:
  - IDLE: on KEY(k), cand=k, cnt=1, go to PRESS. If DEBOUNCE=1, accept immediately.
  - PRESS:
    - KEY(cand): cnt+1; when cnt reaches DEBOUNCE, accept cand and go to HELD.
    - Any other result (NONE, MULTI or a different key): go to IDLE, cnt=0. A different key is not adopted until the next scan.
  - HELD:
    - NONE: cnt=1, go to RELEASE.
    - Anything else: stay in HELD. Second keys and MULTI are ignored; no new event.
  - RELEASE:
    - NONE: cnt+1; at DEBOUNCE go to IDLE, key_down=0.
    - Anything else: go to HELD, cnt=0. A bounce never re-fires.
- Accept:
  - Asserts exactly one of newhex/newop/eq for one cycle, in the cycle after the accepting scan-end sample.
  - hexcode or opcode updates in the same cycle as its pulse; the other field is unchanged.
  - key_down rises with the pulse.
- Latency: clean press at a scan boundary gives a pulse after DEBOUNCE full scans + 1 cycle, plus synchroniser delay (2 cycles).
- Mid-scan press: the partial scan may report NONE or KEY; it counts normally.
- At most one event per press; pulses are never simultaneous; no event while key_down=1.
- Async reset mid-operation: immediate return to reset values. A key held through reset release must be re-debounced and is then accepted once.

Test Plan (SCAN_DIV=4, DEBOUNCE=3):
- Reset/idle: hold reset=0, then release with rows all high → col_n=111110, then 111101 after 4 cycles, cycling through all 6 columns; no pulses for 200 cycles.
- Hex press: key c=2,r=3 (k=11) held 10 scans → one newhex pulse, hexcode=4'hB, key_down=1; release 3 scans → key_down=0; no second pulse.
- Operator and equals: k=18 → one newop, opcode=2'b10, hexcode unchanged; then k=20 → one eq pulse, opcode still 2'b10.
- Bounce: k=5 toggling press/release every scan for 8 scans → no pulse. Held k=5 with a single-scan release glitch → exactly one newhex, hexcode=5.
- Multi/unused: k=1 and k=6 pressed together 6 scans → no event. k=22 held → no event. k=1 held, then k=6 added → one newhex (1) only.
- Async reset mid-press: assert reset during PRESS and during HELD → outputs 0 immediately. Key still held after release → exactly one pulse after 3 scans.
